// File: rtl/bsg_clk_downsample_ctr.sv
// ============================================================================
// Module      : bsg_clk_downsample_ctr
// Description : Programmable clock divider. It toggles a registered clock every
//               val+1 input cycles. Define BSG_CLK_DOWNSAMPLE_STROBE_EN to add
//               strobe_o, a one-cycle pulse on each rising edge of clk_r_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Stand-in for the library's hardened flop cell: a plain D flop with no reset.
module bsg_clk_downsample_ctr_hard_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);
  always_ff @(posedge clk_i) begin
    q_o <= d_i;
  end
endmodule

module bsg_clk_downsample_ctr #(
  parameter int width_p  = 2,
  parameter bit harden_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] val_i,
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
  output logic               clk_r_o,
  output logic               strobe_o
`else
  output logic               clk_r_o
`endif
);

  logic [width_p-1:0] ctr_q, ctr_d;
  logic [width_p-1:0] val_q;
  logic               clk_q, clk_d;
  logic               terminal;

  assign terminal = (ctr_q == val_q);

  // The reset is folded into D so that the hardened cells need no reset pin.
  always_comb begin
    ctr_d = ctr_q + width_p'(1);
    clk_d = clk_q;
    if (reset_i) begin
      ctr_d = '0;
      clk_d = 1'b0;
    end else if (terminal) begin
      ctr_d = '0;
      clk_d = ~clk_q;
    end
  end

  // A new val_i is taken only at a terminal count. This lets the current half-period finish.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      val_q <= val_i;
    end else if (terminal) begin
      val_q <= val_i;
    end
  end

  generate
    if (harden_p) begin : g_hard
      bsg_clk_downsample_ctr_hard_dff #(.width_p(width_p + 1)) u_state (
        .clk_i (clk_i),
        .d_i   ({ctr_d, clk_d}),
        .q_o   ({ctr_q, clk_q})
      );
    end else begin : g_soft
      always_ff @(posedge clk_i) begin
        ctr_q <= ctr_d;
        clk_q <= clk_d;
      end
    end
  endgenerate

  assign clk_r_o = clk_q;

`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
  logic strobe_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= terminal & ~clk_q;
    end
  end

  assign strobe_o = strobe_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_clk_downsample_ctr.sv
// ============================================================================
// Module      : tb_bsg_clk_downsample_ctr
// Description : Directed bench for bsg_clk_downsample_ctr. It runs a soft
//               instance and a hardened instance side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_clk_downsample_ctr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] val = 2'd1;
  logic       clk0, clk1;
  logic       stb0, stb1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bsg_clk_downsample_ctr #(.width_p(2), .harden_p(1'b0)) dut0 (
    .clk_i    (clk),
    .reset_i  (rst),
    .val_i    (val),
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
    .clk_r_o  (clk0),
    .strobe_o (stb0)
`else
    .clk_r_o  (clk0)
`endif
  );

  bsg_clk_downsample_ctr #(.width_p(2), .harden_p(1'b1)) dut1 (
    .clk_i    (clk),
    .reset_i  (rst),
    .val_i    (val),
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
    .clk_r_o  (clk1),
    .strobe_o (stb1)
`else
    .clk_r_o  (clk1)
`endif
  );

`ifndef BSG_CLK_DOWNSAMPLE_STROBE_EN
  assign stb0 = 1'b0;
  assign stb1 = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for n edges. Outputs must be low on every reset edge.
  task automatic do_reset(input logic [1:0] v, input int n);
    val = v;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check("reset_clk0", {31'd0, clk0}, 32'd0);
      check("reset_clk1", {31'd0, clk1}, 32'd0);
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
      check("reset_strobe", {31'd0, stb0}, 32'd0);
`endif
    end
    rst = 1'b0;
  endtask

  // Bit i of pat (and of spat) is the value expected after edge i+1.
  task automatic expect_seq(input string tag, input logic [15:0] pat,
                            input logic [15:0] spat, input int n, input bit chk_stb);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_soft"}, {31'd0, clk0}, {31'd0, pat[i]});
      check({tag, "_hard"}, {31'd0, clk1}, {31'd0, pat[i]});
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
      if (chk_stb) begin
        check({tag, "_strobe"}, {31'd0, stb0}, {31'd0, spat[i]});
      end
`endif
    end
  endtask

  logic [1:0] m_ctr, m_val;
  logic       m_clk, m_stb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Divide by 4. The first rise comes 2 edges after release. The strobe matches each rise.
    do_reset(2'd1, 3);
    expect_seq("div4", 16'h0066, 16'h0022, 8, 1'b1);

    // Divide by 2.
    do_reset(2'd0, 2);
    expect_seq("div2", 16'h5555, 16'h0000, 8, 1'b0);

    // Divide by 8.
    do_reset(2'd3, 2);
    expect_seq("div8", 16'h7878, 16'h0000, 16, 1'b0);

    // val changes 1->3 partway through the high half. That half keeps 2 cycles. Later halves use 4.
    do_reset(2'd1, 2);
    expect_seq("midchg_a", 16'h0006, 16'h0000, 3, 1'b0);
    val = 2'd3;
    expect_seq("midchg_b", 16'h00F0, 16'h0000, 9, 1'b0);

    // A reset pulse while clk_r_o=1 and ctr=1 restarts the schedule.
    do_reset(2'd1, 2);
    expect_seq("prerst", 16'h0006, 16'h0000, 3, 1'b0);
    do_reset(2'd1, 1);
    expect_seq("postrst", 16'h0066, 16'h0022, 8, 1'b1);

    // Random val changes and occasional resets, checked against a reference model.
    do_reset(2'd2, 2);
    m_ctr = 2'd0;
    m_clk = 1'b0;
    m_val = 2'd2;
    m_stb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) val = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 39) == 0);
      if (rst) begin
        m_stb = 1'b0;
        m_ctr = 2'd0;
        m_clk = 1'b0;
        m_val = val;
      end else if (m_ctr == m_val) begin
        m_stb = ~m_clk;
        m_ctr = 2'd0;
        m_clk = ~m_clk;
        m_val = val;
      end else begin
        m_stb = 1'b0;
        m_ctr = m_ctr + 2'd1;
      end
      tick();
      check("rand_soft", {31'd0, clk0}, {31'd0, m_clk});
      check("rand_hard", {31'd0, clk1}, {31'd0, m_clk});
`ifdef BSG_CLK_DOWNSAMPLE_STROBE_EN
      check("rand_strobe_soft", {31'd0, stb0}, {31'd0, m_stb});
      check("rand_strobe_hard", {31'd0, stb1}, {31'd0, m_stb});
`endif
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
